// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO of {word, parity enable, parity type, stop2}.
// Frames run back to back while the FIFO has entries; TX_OUT is registered and idles high.
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  fifo_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DATA_WIDTH + 3;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [15:0]    CPB_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     LAST_BIT  = 4'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [ENT_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count, count_nxt;
    logic                  wr_en, rd_en;
    logic [ENT_W-1:0]      rd_data;

    logic [2:0]            state;
    logic [15:0]           bit_cnt;
    logic [3:0]            bit_idx;
    logic                  stop_second;
    logic                  bit_done, stop_last, frame_end;

    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit, par_en_q, stop2_q;

    assign rd_data   = mem[rd_ptr];
    assign bit_done  = (bit_cnt == CPB_LAST);
    assign stop_last = !stop2_q || stop_second;
    assign frame_end = (state == STOP) && bit_done && stop_last;
    assign busy      = (state != IDLE);

    // A write while full is dropped even if the FSM frees a slot on the same edge.
    assign wr_en = Data_Valid && !fifo_full;
    assign rd_en = !fifo_empty && ((state == IDLE) || frame_end);

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nxt;
            fifo_full  <= (count_nxt == DEPTH_CNT);
            fifo_empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {P_DATA, PAR_EN, PAR_TYP, STOP2};
    end

    // Popped entry is latched here so later input changes cannot touch the frame.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            shreg    <= rd_data[ENT_W-1:3];
            par_bit  <= (^rd_data[ENT_W-1:3]) ^ rd_data[1];
            par_en_q <= rd_data[2];
            stop2_q  <= rd_data[0];
        end else if (bit_done && ((state == START) || (state == DATA))) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            TX_OUT      <= 1'b1;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            if (!fifo_empty) begin
                state  <= START;
                TX_OUT <= 1'b0;
            end else begin
                TX_OUT <= 1'b1;
            end
        end else if (!bit_done) begin
            bit_cnt <= bit_cnt + 16'd1;
        end else begin
            bit_cnt <= '0;
            case (state)
                START: begin
                    state   <= DATA;
                    TX_OUT  <= shreg[0];
                    bit_idx <= '0;
                end
                DATA: begin
                    if (bit_idx == LAST_BIT) begin
                        stop_second <= 1'b0;
                        if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        TX_OUT  <= shreg[0];
                    end
                end
                PARITY: begin
                    state       <= STOP;
                    TX_OUT      <= 1'b1;
                    stop_second <= 1'b0;
                end
                STOP: begin
                    // Next frame starts straight from the stop bit when work is queued.
                    if (!stop_last) begin
                        stop_second <= 1'b1;
                    end else if (!fifo_empty) begin
                        state  <= START;
                        TX_OUT <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three parameterisations share clk and rst.
module tb_uart_tx_fifo;

    logic clk;
    logic rst;

    logic [7:0] a_data;
    logic       a_vld, a_pen, a_ptyp, a_stop2;
    logic       a_tx, a_busy, a_full, a_empty;

    logic [7:0] b_data;
    logic       b_vld, b_pen, b_ptyp, b_stop2;
    logic       b_tx, b_busy, b_full, b_empty;

    logic [6:0] c_data;
    logic       c_vld, c_pen, c_ptyp, c_stop2;
    logic       c_tx, c_busy, c_full, c_empty;

    int n_tests;
    int n_fail;

    uart_tx_fifo dut_a (
        .clk(clk), .rst(rst), .P_DATA(a_data), .Data_Valid(a_vld), .PAR_EN(a_pen),
        .PAR_TYP(a_ptyp), .STOP2(a_stop2), .TX_OUT(a_tx), .busy(a_busy),
        .fifo_full(a_full), .fifo_empty(a_empty)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4)) dut_b (
        .clk(clk), .rst(rst), .P_DATA(b_data), .Data_Valid(b_vld), .PAR_EN(b_pen),
        .PAR_TYP(b_ptyp), .STOP2(b_stop2), .TX_OUT(b_tx), .busy(b_busy),
        .fifo_full(b_full), .fifo_empty(b_empty)
    );

    uart_tx_fifo #(.DATA_WIDTH(7)) dut_c (
        .clk(clk), .rst(rst), .P_DATA(c_data), .Data_Valid(c_vld), .PAR_EN(c_pen),
        .PAR_TYP(c_ptyp), .STOP2(c_stop2), .TX_OUT(c_tx), .busy(c_busy),
        .fifo_full(c_full), .fifo_empty(c_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_tests++; if (a_tx !== 1'b1)    begin n_fail++; $display("FAIL reset_tx: got %b want 1", a_tx); end
        n_tests++; if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_tests++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", a_empty); end
        n_tests++; if (a_full !== 1'b0)  begin n_fail++; $display("FAIL reset_full: got %b want 0", a_full); end
        n_tests++; if (b_tx !== 1'b1 || c_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx_bc: got %b%b want 11", b_tx, c_tx); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_frame_a5();
        logic [0:10] exp_bits;
        exp_bits = 11'b01010010101;
        @(negedge clk);
        a_data = 8'hA5; a_pen = 1'b1; a_ptyp = 1'b0; a_stop2 = 1'b0; a_vld = 1'b1;
        @(negedge clk);
        a_vld = 1'b0; a_data = 8'h00; a_pen = 1'b0; a_ptyp = 1'b1; a_stop2 = 1'b1;
        n_tests++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL a5_pre: tx %b busy %b want 1 0", a_tx, a_busy); end
        n_tests++; if (a_empty !== 1'b0) begin n_fail++; $display("FAIL a5_queued: empty %b want 0", a_empty); end
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_tests++;
            if (a_tx !== exp_bits[i] || a_busy !== 1'b1) begin
                n_fail++; $display("FAIL a5_bit%0d: tx %b busy %b want %b 1", i, a_tx, a_busy, exp_bits[i]);
            end
        end
        @(negedge clk);
        n_tests++; if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_empty !== 1'b1) begin
            n_fail++; $display("FAIL a5_post: tx %b busy %b empty %b want 1 0 1", a_tx, a_busy, a_empty);
        end
    endtask

    task automatic test_parity_odd_stop2();
        logic [0:11] exp_bits;
        exp_bits = 12'b010100101111;
        @(negedge clk);
        b_data = 8'hA5; b_pen = 1'b1; b_ptyp = 1'b1; b_stop2 = 1'b1; b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0; b_data = 8'hFF; b_pen = 1'b0; b_stop2 = 1'b0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            n_tests++;
            if (b_tx !== exp_bits[c/4] || b_busy !== 1'b1) begin
                n_fail++; $display("FAIL odd_cycle%0d: tx %b busy %b want %b 1", c, b_tx, b_busy, exp_bits[c/4]);
            end
        end
        @(negedge clk);
        n_tests++; if (b_tx !== 1'b1 || b_busy !== 1'b0) begin
            n_fail++; $display("FAIL odd_post: tx %b busy %b want 1 0", b_tx, b_busy);
        end
    endtask

    task automatic test_no_parity();
        logic [0:8] exp_bits;
        exp_bits = 9'b011111111;
        @(negedge clk);
        c_data = 7'h7F; c_pen = 1'b0; c_ptyp = 1'b0; c_stop2 = 1'b0; c_vld = 1'b1;
        @(negedge clk);
        c_vld = 1'b0; c_pen = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_tests++;
            if (c_tx !== exp_bits[i] || c_busy !== 1'b1) begin
                n_fail++; $display("FAIL nopar_bit%0d: tx %b busy %b want %b 1", i, c_tx, c_busy, exp_bits[i]);
            end
        end
        @(negedge clk);
        n_tests++; if (c_tx !== 1'b1 || c_busy !== 1'b0) begin
            n_fail++; $display("FAIL nopar_post: tx %b busy %b want 1 0", c_tx, c_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic       stream [50];
        logic [7:0] w;
        for (int k = 0; k < 5; k++) begin
            w = 8'(k + 1);
            stream[k*10] = 1'b0;
            for (int b = 0; b < 8; b++) stream[k*10 + 1 + b] = w[b];
            stream[k*10 + 9] = 1'b1;
        end
        a_pen = 1'b0; a_ptyp = 1'b0; a_stop2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                n_tests++;
                if (a_tx !== stream[k-2] || a_busy !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_cycle%0d: tx %b busy %b want %b 1", k - 2, a_tx, a_busy, stream[k-2]);
                end
            end
            if (k == 4) begin
                n_tests++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL b2b_three: full %b want 0", a_full); end
            end
            if (k == 5) begin
                n_tests++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: full %b want 1", a_full); end
            end
            a_data = 8'(k + 1);
            a_vld  = 1'b1;
        end
        for (int e = 6; e < 52; e++) begin
            @(negedge clk);
            if (e == 6) begin
                a_vld = 1'b0;
                n_tests++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL b2b_drop6: full %b want 1", a_full); end
            end
            n_tests++;
            if (a_tx !== stream[e-2] || a_busy !== 1'b1) begin
                n_fail++; $display("FAIL b2b_cycle%0d: tx %b busy %b want %b 1", e - 2, a_tx, a_busy, stream[e-2]);
            end
            if (e == 11) begin
                n_tests++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL b2b_prepop: full %b want 1", a_full); end
                a_data = 8'h77;
                a_vld  = 1'b1;
            end
            if (e == 12) begin
                a_vld = 1'b0;
                n_tests++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL b2b_pop_drop: full %b want 0", a_full); end
            end
        end
        @(negedge clk);
        n_tests++; if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_empty !== 1'b1) begin
            n_fail++; $display("FAIL b2b_post: tx %b busy %b empty %b want 1 0 1", a_tx, a_busy, a_empty);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] words [3];
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hC3;
        a_pen = 1'b1; a_ptyp = 1'b0; a_stop2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_data = words[k];
            a_vld  = 1'b1;
        end
        @(negedge clk);
        a_vld = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (a_tx !== 1'b0 || a_busy !== 1'b1 || a_empty !== 1'b0) begin
            n_fail++; $display("FAIL mid_bit3: tx %b busy %b empty %b want 0 1 0", a_tx, a_busy, a_empty);
        end
        rst = 1'b1;
        #1;
        n_tests++; if (a_tx !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_tx: got %b want 1", a_tx); end
        n_tests++; if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", a_busy); end
        n_tests++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty: got %b want 1", a_empty); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            n_tests++;
            if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_after%0d: tx %b busy %b want 1 0", i, a_tx, a_busy);
            end
        end
    endtask

    task automatic test_write_after_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a_data = 8'h81; a_pen = 1'b0; a_ptyp = 1'b0; a_stop2 = 1'b0; a_vld = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        n_tests++; if (a_empty !== 1'b0 || a_tx !== 1'b1) begin
            n_fail++; $display("FAIL first_write: empty %b tx %b want 0 1", a_empty, a_tx);
        end
        @(negedge clk);
        n_tests++; if (a_tx !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL first_start: tx %b busy %b want 0 1", a_tx, a_busy);
        end
        @(negedge clk);
        n_tests++; if (a_tx !== 1'b1) begin n_fail++; $display("FAIL first_bit0: tx %b want 1", a_tx); end
        repeat (9) @(negedge clk);
        n_tests++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL first_post: tx %b busy %b want 1 0", a_tx, a_busy);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        a_data = '0; a_vld = 1'b0; a_pen = 1'b0; a_ptyp = 1'b0; a_stop2 = 1'b0;
        b_data = '0; b_vld = 1'b0; b_pen = 1'b0; b_ptyp = 1'b0; b_stop2 = 1'b0;
        c_data = '0; c_vld = 1'b0; c_pen = 1'b0; c_ptyp = 1'b0; c_stop2 = 1'b0;
        test_reset();
        test_frame_a5();
        test_parity_odd_stop2();
        test_no_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_write_after_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, range 2..16.
REQ-003 Parameter CLKS_PER_BIT, default 1, clk cycles per serial bit; range 1..65535.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, asynchronous, active-high reset.
REQ-006 Port P_DATA, input, DATA_WIDTH, parallel word to transmit.
REQ-007 Port Data_Valid, input, 1, write strobe for P_DATA, qualified by fifo_full low.
REQ-008 Port PAR_EN, input, 1, parity bit enable; stored per word.
REQ-009 Port PAR_TYP, input, 1, parity type: 0 even, 1 odd; stored per word.
REQ-010 Port STOP2, input, 1, 1 selects two stop bits, 0 selects one; stored per word.
REQ-011 Port TX_OUT, output, 1, registered serial line; idles high.
REQ-012 Port busy, output, 1, high while a frame is on the line.
REQ-013 Port fifo_full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-014 Port fifo_empty, output, 1, FIFO holds zero entries.

Function
REQ-015 The block SHALL write {P_DATA, PAR_EN, PAR_TYP, STOP2} into the FIFO on a clk edge where Data_Valid=1 and fifo_full=0.
REQ-016 The block SHALL silently drop a write when fifo_full=1, including the cycle in which the FSM pops an entry.
REQ-017 The FIFO SHALL use wrapping read/write pointers and a log2(FIFO_DEPTH)+1-bit count; full/empty SHALL be registered and derived from count.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with fifo_empty=0 the FSM SHALL pop one entry into a shift register and enter START on the next edge.
REQ-020 Latency: word written at edge N into an empty, idle block SHALL drive TX_OUT=0 from edge N+1.
REQ-021 Each state SHALL hold its bit for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that reloads on every bit boundary.
REQ-022 START SHALL drive 0; DATA SHALL drive DATA_WIDTH bits LSB first via a bit index counter; PARITY is entered only if the stored PAR_EN=1.
REQ-023 Parity bit SHALL equal XOR of the stored word for PAR_TYP=0 and its inverse for PAR_TYP=1.
REQ-024 STOP SHALL drive 1 for one bit time, or two bit times if stored STOP2=1.
REQ-025 At the end of STOP the FSM SHALL go directly to START with a new pop if fifo_empty=0, with no idle cycle; otherwise to IDLE.
REQ-026 busy SHALL be 1 in START, DATA, PARITY, STOP and 0 in IDLE.
REQ-027 TX_OUT SHALL be 1 in IDLE.
REQ-028 Changes on PAR_EN, PAR_TYP, STOP2 or P_DATA after a word is accepted SHALL NOT affect that word's frame.
REQ-029 A simultaneous write and pop with the FIFO neither full nor empty SHALL leave the count unchanged and keep both entries' order.
REQ-030 With CLKS_PER_BIT=1 the frame length SHALL be 1+DATA_WIDTH+PAR_EN+1+STOP2 cycles.

Reset
REQ-031 Asserting rst SHALL immediately force state IDLE, TX_OUT=1, busy=0, fifo_empty=1, fifo_full=0, and set pointers, count and counters to 0.
REQ-032 Reset mid-frame SHALL abort the frame and discard all FIFO contents; no partial frame SHALL resume after release.
REQ-033 The first write SHALL be accepted on the first clk edge after rst deasserts.

Verification
REQ-034 Defaults, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop); busy high for 11 cycles.
REQ-035 Same word with PAR_TYP=1, STOP2=1, CLKS_PER_BIT=4 -> parity bit 1, each bit held 4 cycles, frame 48 cycles.
REQ-036 Write 5 words back-to-back with FIFO_DEPTH=4 while idle -> first popped immediately, remaining 4 stored, fifo_full=1, sixth write dropped; 5 frames transmitted contiguously with no idle cycle between.
REQ-037 PAR_EN=0, DATA_WIDTH=7, P_DATA=0x7F -> frame 0,1,1,1,1,1,1,1,1 (9 cycles), no parity bit.
REQ-038 Assert rst during DATA bit 3 with 2 words queued -> TX_OUT=1, busy=0, fifo_empty=1 without a clock edge; no further frames after release.
REQ-039 Write while fifo_full=1 in the same cycle the FSM pops -> write dropped, count decrements to FIFO_DEPTH-1.
